keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  - Drives a 4x4 matrix keypad: walks active-low column strobes, samples active-low rows, encodes the pressed key.
//  - Provides the raw key_code/key_pressed pair consumed by the downstream debouncer (its sig_in/key_pressed).
//  - Reports raw contact state only; bounce filtering is downstream.
// PARAMETERS
//  - SETTLE_CYCLES  4   cycles each column is driven before rows are evaluated; must be >= 3 (covers 2-flop sync)
//  - CNT_W          16  settle-counter width; SETTLE_CYCLES must fit in CNT_W bits
// PORTS
//  - clk          in   1  system clock; all state updates on posedge
//  - reset        in   1  synchronous, active-high reset
//  - rows_raw     in   4  keypad rows, asynchronous, active-low (pulled up externally)
//  - cols         out  4  column strobes, active-low, exactly one bit low at all times
//  - key_code     out  4  hex code of the detected key, held after release
//  - key_pressed  out  1  high while the detected key remains pressed
// BEHAVIOUR
//  - rows_raw passes through a 2-flop synchronizer -> rows_sync; 2-cycle input latency.
//  - Reset (sync): state=SCAN, col_idx=0, cols=4'b1110, counter=0, key_code=4'h0, key_pressed=0, sync flops=4'b1111.
//  - cols = ~(4'b0001 << col_idx), driven from registered col_idx.
//  - SCAN: counter increments each cycle. On the cycle where counter==SETTLE_CYCLES-1, rows_sync is evaluated:
//    - no row low: next edge col_idx<=col_idx+1 (wraps 3->0), counter<=0, stay SCAN.
//    - valid row low: next edge state<=HOLD, held_row<=row, key_code<=MAP[row][col_idx], key_pressed<=1; col_idx held.
//  - HOLD: cols unchanged; counter held at 0.
//    - rows_sync[held_row]==1: next edge key_pressed<=0, state<=SCAN, col_idx<=col_idx+1 (wrap), counter<=0.
//    - Other rows going low/high while held_row is low: ignored; key_code does not change.
//  - Each column dwells exactly SETTLE_CYCLES cycles in SCAN; full idle sweep = 4*SETTLE_CYCLES cycles.
//  - Row priority when several rows low (macro off): lowest row index wins.
//  - MAP (row r, col c):
//    - r0: 1 2 3 A
//    - r1: 4 5 6 B
//    - r2: 7 8 9 C
//    - r3: E 0 F D
//  - key_code updates only on SCAN->HOLD; it keeps its value after release until the next detection.
//  - Reset asserted in any state (including HOLD): next edge restores all reset values; key_pressed drops that edge.
//  - Key held through reset: re-detected on the first column-0 evaluation after reset, if in column 0.
//  - Press and release shorter than the sync+settle window may be missed; accepted behaviour.
//  - Invalid state encodings recover to SCAN with reset values.
// CONFIGURATION
//  - KEYPAD_MULTIKEY_REJECT_EN defined:
//    - SCAN evaluation with >1 row low in the active column is treated as "no key"; scan advances.
//    - In HOLD, a second row going low does not release; release is still on held_row only.
//  - KEYPAD_MULTIKEY_REJECT_EN undefined: lowest-index low row is accepted (priority rule above).
// TESTING
//  - Reset, rows_raw=4'hF, SETTLE_CYCLES=4:
//    - cols 1110 for 4 cycles, then 1101, 1011, 0111, back to 1110 (4-cycle dwell each).
//    - key_pressed=0 and key_code=0 throughout.
//  - Hold row1 low (rows_raw=4'b1101) while cols=1011:
//    - key_code=4'h6 and key_pressed=1 at the column's evaluation edge; cols stays 1011.
//  - Release the above (rows_raw=4'hF):
//    - key_pressed=0 within 3 cycles; cols advances to 0111; key_code stays 4'h6.
//  - Rows 0 and 2 low in column 0 (rows_raw=4'b1010):
//    - macro off: key_code=4'h1, key_pressed=1.
//    - macro on: no detection, cols advances to 1101.
//  - Key '0' (row3, col1) pressed, then reset pulsed mid-HOLD:
//    - cycle after reset: cols=1110, key_pressed=0, key_code=0.
//    - key re-detected (code 4'h0, key_pressed=1) when column 1 is evaluated.
//  - Key 'D' (row3, col3) held across the col3 evaluation:
//    - key_code=4'hD; after release, scan wraps to cols=1110.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix rows/columns plus the encoded key pair.
// master = scanner side, slave = keypad/downstream-debouncer side.
interface keypad_scanner_if;
    logic [3:0] rows_raw;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_pressed;

    modport master (
        input  rows_raw,
        output cols,
        output key_code,
        output key_pressed
    );

    modport slave (
        output rows_raw,
        input  cols,
        input  key_code,
        input  key_pressed
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low column strobes, samples synchronized rows, encodes the key.
// Optional build macro KEYPAD_MULTIKEY_REJECT_EN: several rows low in one column reads as "no key".
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        HOLD = 2'd1
    } state_t;

    state_t           state;
    logic [1:0]       col_idx;
    logic [1:0]       held_row;
    logic [CNT_W-1:0] counter;
    logic [3:0]       sync_q1;
    logic [3:0]       rows_sync;
    logic [3:0]       cols_q;
    logic [3:0]       key_code_q;
    logic             key_pressed_q;

    logic [1:0]       col_inc_c;
    logic             row_found_c;
    logic [1:0]       row_sel_c;

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign col_inc_c = col_idx + 2'd1;

    // Lowest-index low row wins; optionally reject simultaneous rows.
    always_comb begin
        row_found_c = 1'b0;
        row_sel_c   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_sync[i]) begin
                row_found_c = 1'b1;
                row_sel_c   = 2'(i);
            end
        end
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        if ($countones(~rows_sync) > 1) begin
            row_found_c = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SCAN;
            col_idx       <= 2'd0;
            held_row      <= 2'd0;
            counter       <= '0;
            sync_q1       <= 4'b1111;
            rows_sync     <= 4'b1111;
            cols_q        <= 4'b1110;
            key_code_q    <= 4'h0;
            key_pressed_q <= 1'b0;
        end else begin
            sync_q1   <= kp.rows_raw;
            rows_sync <= sync_q1;
            case (state)
                SCAN: begin
                    if (counter >= CNT_LAST) begin
                        counter <= '0;
                        if (row_found_c) begin
                            state         <= HOLD;
                            held_row      <= row_sel_c;
                            key_code_q    <= key_map(row_sel_c, col_idx);
                            key_pressed_q <= 1'b1;
                        end else begin
                            col_idx <= col_inc_c;
                            cols_q  <= col_strobe(col_inc_c);
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                HOLD: begin
                    counter <= '0;
                    // Only the held row releases; other rows in this column are ignored.
                    if (rows_sync[held_row]) begin
                        state         <= SCAN;
                        key_pressed_q <= 1'b0;
                        col_idx       <= col_inc_c;
                        cols_q        <= col_strobe(col_inc_c);
                    end
                end
                default: begin
                    state         <= SCAN;
                    col_idx       <= 2'd0;
                    held_row      <= 2'd0;
                    counter       <= '0;
                    sync_q1       <= 4'b1111;
                    rows_sync     <= 4'b1111;
                    cols_q        <= 4'b1110;
                    key_code_q    <= 4'h0;
                    key_pressed_q <= 1'b0;
                end
            endcase
        end
    end

    assign kp.cols        = cols_q;
    assign kp.key_code    = key_code_q;
    assign kp.key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner with a behavioural keypad and scanner reference model.
module tb_keypad_scanner;

    localparam int SETTLE = 4;

    logic        clk;
    logic        reset;
    logic [15:0] keys;     // bit r*4+c set = key at row r, column c held down

    int vectors;
    int miscompares;

    keypad_scanner_if kif();

    keypad_scanner #(.SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a held key shorts its row to its column while that column is strobed low.
    always_comb begin
        kif.rows_raw = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!kif.cols[c] && keys[r*4+c]) kif.rows_raw[r] = 1'b0;
            end
        end
    end

    int key_tbl [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    function automatic logic [3:0] exp_cols(input int k);
        logic [3:0] one;
        one = 4'h1 << k;
        return 4'hF ^ one;
    endfunction

    function automatic logic [3:0] rows_for(input logic [15:0] k, input int col);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++) if (k[i*4+col]) r[i] = 1'b0;
        return r;
    endfunction

    function automatic int pick_row(input logic [3:0] rs);
        int lows;
        int first;
        lows  = 0;
        first = -1;
        for (int r = 0; r < 4; r++) begin
            if (!rs[r]) begin
                lows++;
                if (first < 0) first = r;
            end
        end
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        if (lows > 1) first = -1;
`endif
        return first;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: which column, how long it has dwelt, held key, rows seen 1 and 2 edges back.
    bit         m_valid;
    bit         m_holding;
    int         m_col;
    int         m_dwell;
    int         m_row;
    logic [3:0] m_code;
    bit         m_pressed;
    logic [3:0] seen1, seen2;

    task model_step(input logic rst, input logic [15:0] k);
        logic [3:0] now_rows;
        int pick;
        now_rows = rows_for(k, m_col);
        if (rst) begin
            m_valid = 1'b1; m_holding = 1'b0; m_col = 0; m_dwell = 0; m_row = 0;
            m_code = 4'h0; m_pressed = 1'b0; seen1 = 4'hF; seen2 = 4'hF;
        end else begin
            if (!m_holding) begin
                if (m_dwell == SETTLE - 1) begin
                    m_dwell = 0;
                    pick = pick_row(seen2);
                    if (pick >= 0) begin
                        m_holding = 1'b1;
                        m_row     = pick;
                        m_code    = 4'(key_tbl[pick*4+m_col]);
                        m_pressed = 1'b1;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end else begin
                    m_dwell++;
                end
            end else if (seen2[m_row]) begin
                m_holding = 1'b0;
                m_pressed = 1'b0;
                m_col     = (m_col + 1) % 4;
                m_dwell   = 0;
            end
            seen2 = seen1;
            seen1 = now_rows;
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        m_valid = 1'b0;
        forever begin
            @(posedge clk);
            model_step(reset, keys);
            #1;
            if (m_valid) begin
                check("cols",        16'(kif.cols),        16'(exp_cols(m_col)));
                check("key_code",    16'(kif.key_code),    16'(m_code));
                check("key_pressed", 16'(kif.key_pressed), 16'(m_pressed));
            end
        end
    end

    task automatic wait_pressed(input logic val, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (kif.key_pressed !== val && n < budget);
        check("wait_key_pressed", 16'(kif.key_pressed), 16'(val));
    endtask

    task automatic wait_col_entry(input int col, input int budget);
        logic [3:0] prev;
        logic [3:0] target;
        int n;
        target = exp_cols(col);
        prev   = kif.cols;
        n      = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((kif.cols == target && prev != target) || n >= budget) break;
            prev = kif.cols;
        end
        check("wait_col_entry", 16'(kif.cols), 16'(target));
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        keys        = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_cols",    16'(kif.cols),        16'h000E);
        check("rst_code",    16'(kif.key_code),    16'h0000);
        check("rst_pressed", 16'(kif.key_pressed), 16'h0000);
        reset = 1'b0;

        // Idle sweep: four-cycle dwell per column, then wrap.
        check("sweep0", 16'(kif.cols), 16'h000E);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("sweep", 16'(kif.cols), 16'(exp_cols((i / 4) % 4)));
            check("sweep_pressed", 16'(kif.key_pressed), 16'h0000);
        end

        // Key '6' at row1/col2.
        wait_col_entry(2, 40);
        keys[6] = 1'b1;
        wait_pressed(1'b1, 10, n);
        check("k6_code", 16'(kif.key_code), 16'h0006);
        check("k6_cols", 16'(kif.cols),     16'h000B);
        repeat (2) @(negedge clk);
        check("k6_hold_cols", 16'(kif.cols), 16'h000B);
        keys = 16'h0;
        repeat (3) @(negedge clk);
        check("k6_rel_pressed", 16'(kif.key_pressed), 16'h0000);
        check("k6_rel_cols",    16'(kif.cols),        16'h0007);
        check("k6_rel_code",    16'(kif.key_code),    16'h0006);

        // Rows 0 and 2 low in column 0.
        wait_col_entry(0, 40);
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        repeat (4) @(negedge clk);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        check("multi_pressed", 16'(kif.key_pressed), 16'h0000);
        check("multi_cols",    16'(kif.cols),        16'h000D);
`else
        check("multi_pressed", 16'(kif.key_pressed), 16'h0001);
        check("multi_code",    16'(kif.key_code),    16'h0001);
`endif
        keys = 16'h0;
        wait_pressed(1'b0, 10, n);

        // Key '0' at row3/col1, reset pulsed while held.
        wait_col_entry(1, 40);
        keys[13] = 1'b1;
        wait_pressed(1'b1, 10, n);
        check("k0_code", 16'(kif.key_code), 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("k0_rst_cols",    16'(kif.cols),        16'h000E);
        check("k0_rst_pressed", 16'(kif.key_pressed), 16'h0000);
        check("k0_rst_code",    16'(kif.key_code),    16'h0000);
        wait_pressed(1'b1, 30, n);
        check("k0_redetect_cycles", 16'(n),                16'd8);
        check("k0_redetect_cols",   16'(kif.cols),         16'h000D);
        check("k0_redetect_code",   16'(kif.key_code),     16'h0000);
        keys = 16'h0;
        wait_pressed(1'b0, 10, n);

        // Key 'D' at row3/col3, then wrap to column 0 on release.
        wait_col_entry(3, 40);
        keys[15] = 1'b1;
        wait_pressed(1'b1, 10, n);
        check("kD_code", 16'(kif.key_code), 16'h000D);
        keys = 16'h0;
        wait_pressed(1'b0, 10, n);
        check("kD_wrap_cols", 16'(kif.cols), 16'h000E);
        check("kD_keep_code", 16'(kif.key_code), 16'h000D);

        // Random key activity with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       keys = 16'h0;
                    1, 2:    keys = 16'h1 << $urandom_range(0, 15);
                    default: keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                endcase
            end
        end
        reset = 1'b0;
        keys  = 16'h0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
